apb_requester: RTL and testbench
================================

# apb_requester

APB initiator that turns single-beat command requests into APB3-style SETUP/ACCESS transfers toward a completer, such as the SPI register bridge, and returns the read data or completion status on a response channel. It sits between a local controller (sequencer, DMA or test engine) and the APB bus. It allows one outstanding transfer and enforces a configurable wait-state timeout so a hung completer cannot stall the issuer.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max ACCESS cycles without pready_i before abort; 0 disables timeout
- pclk_i  in  1  clock; all logic on rising edge
- prst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when cmd_valid_i && cmd_ready_o at clock edge
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_W  transfer address
- cmd_wdata_i  in  DATA_W  write data (ignored for reads)
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed when rsp_valid_o && rsp_ready_i at edge
- rsp_rdata_o  out  DATA_W  read data; 0 for writes and timeouts
- rsp_timeout_o  out  1  transfer aborted by timeout
- busy_o  out  1  high in any state other than IDLE
- psel_o, penable_o, pwrite_o  out  1  APB control
- paddr_o  out  ADDR_W; pwdata_o  out  DATA_W  APB address/write data
- prdata_i  in  DATA_W; pready_i  in  1  APB completer returns

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready_o=1, combinational on state. On accept, register cmd_addr_i into paddr_o, cmd_write_i into pwrite_o and cmd_wdata_i into pwdata_o, then go to SETUP.
- SETUP: psel_o=1, penable_o=0 for exactly one cycle, then ACCESS. pready_i is ignored.
- ACCESS: psel_o=1, penable_o=1. The wait counter clears on entry and increments each cycle pready_i is sampled low.
  - pready_i sampled high: capture prdata_i into rsp_rdata_o (reads) or 0 (writes), set rsp_timeout_o=0, go to RESP.
  - TIMEOUT≠0 and the counter reaches TIMEOUT-1 with pready_i low: set rsp_rdata_o=0 and rsp_timeout_o=1, go to RESP.
  - pready_i high on the final timeout cycle: normal completion wins.
- RESP: rsp_valid_o=1, psel_o=0, penable_o=0. Hold the response until rsp_ready_i, then go to IDLE.
- paddr_o, pwrite_o and pwdata_o are stable from SETUP through ACCESS. They hold their last values in RESP and IDLE and change only on command accept.
- Wait counter width is $clog2(TIMEOUT+1). It saturates and never wraps.
- pready_i and prdata_i are ignored outside ACCESS.
- All outputs except cmd_ready_o and busy_o come straight from flops.

## Timing
- Reset (async assert): state IDLE. All outputs 0 while prst_i is high, including cmd_ready_o and busy_o. After deassertion cmd_ready_o=1 and every other output is 0.
- Reset mid-transfer: psel_o and penable_o drop immediately, the command is discarded and no response is issued.
- Command accepted at edge N: psel_o high in cycle N+1 (SETUP), penable_o high from N+2 (ACCESS).
- pready_i sampled high at edge K: psel_o, penable_o low and rsp_valid_o high in cycle K+1.
- Zero-wait completer: accept-to-rsp_valid_o is 3 cycles.
- Completer that raises pready_i one cycle after seeing psel&&penable: ACCESS lasts 2 cycles, so accept-to-rsp_valid_o is 4 cycles.
- Minimum issue interval is 4 cycles: no new command is accepted before the response handshake completes and the FSM returns to IDLE.
- Timeout: penable_o stays high for exactly TIMEOUT cycles, and rsp_valid_o rises in the next cycle.

## Test plan
- Reset: assert prst_i mid-cycle. All outputs go 0 asynchronously; after release cmd_ready_o=1, busy_o=0, psel_o=0.
- Write, zero-wait: cmd write addr 0x8, wdata 0xA5, pready_i tied 1.
  - psel_o high for 2 cycles, penable_o high for 1 cycle, paddr_o=0x8 and pwdata_o=0xA5 throughout.
  - rsp_valid_o 3 cycles after accept with rsp_rdata_o=0, rsp_timeout_o=0.
- Read, 3 wait states: cmd read addr 0xC, completer drives prdata_i=0x5A with pready_i on the 4th ACCESS cycle.
  - penable_o high for 4 cycles; rsp_rdata_o=0x0000005A, rsp_timeout_o=0.
- Timeout, TIMEOUT=16: pready_i stuck at 0.
  - penable_o high for exactly 16 cycles; rsp_timeout_o=1, rsp_rdata_o=0, then bus idle.
  - Repeat with pready_i=1 on the 16th ACCESS cycle: normal completion, rsp_timeout_o=0.
- Backpressure: hold rsp_ready_i low 5 cycles with cmd_valid_i held high.
  - rsp_valid_o and rsp_rdata_o stay stable, cmd_ready_o=0, and the second command is not accepted until the cycle after the response handshake.
- Reset mid-ACCESS: pulse prst_i while penable_o=1.
  - psel_o and penable_o drop immediately, rsp_valid_o never asserts, and the next command runs normally.

Source files
------------

// File: rtl/apb_requester.sv
// apb_requester: single-outstanding APB3 initiator with wait-state timeout.
// Ports: cmd_* request in, rsp_* response out, p* APB bus, busy_o status.
module apb_requester #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk_i,
  input  logic              prst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_timeout_o,
  output logic              busy_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  // Keep the counter at least one bit wide when the timeout is disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_LAST =
    TO_EN ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_to_q, rsp_to_d;

  logic to_hit;

  assign to_hit = TO_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_to_d    = rsp_to_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          paddr_d  = cmd_addr_i;
          pwrite_d = cmd_write_i;
          pwdata_d = cmd_wdata_i;
          psel_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready_i) begin
          rsp_rdata_d = pwrite_q ? '0 : prdata_i;
          rsp_to_d    = 1'b0;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = S_RESP;
        end else if (to_hit) begin
          rsp_rdata_d = '0;
          rsp_to_d    = 1'b1;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = S_RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  // Gated by reset so the issuer sees no ready while reset is held.
  assign cmd_ready_o   = (state_q == S_IDLE) && !prst_i;
  assign busy_o        = (state_q != S_IDLE);
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign pwrite_o      = pwrite_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_timeout_o = rsp_to_q;

endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: table-driven transfers with a response scoreboard,
// plus hand-written backpressure and reset sequences.
module tb_apb_requester;

  logic        pclk_i = 1'b0;
  logic        prst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_write_i = 1'b0;
  logic [31:0] cmd_addr_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_timeout_o;
  logic        busy_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0;

  apb_requester #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(16)
  ) dut (
    .pclk_i       (pclk_i),
    .prst_i       (prst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_write_i  (cmd_write_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_timeout_o(rsp_timeout_o),
    .busy_o       (busy_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .paddr_o      (paddr_o),
    .pwdata_o     (pwdata_o),
    .prdata_i     (prdata_i),
    .pready_i     (pready_i)
  );

  always #5 pclk_i = ~pclk_i;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        tied;
    int          waits;
    logic        stuck;
    logic [31:0] exp_rdata;
    logic        exp_to;
    int          exp_acc;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        to;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[7];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic sb_pop(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_rdata"}, rsp_rdata_o, e.rdata);
      check({tag, "_timeout"}, rsp_timeout_o, e.to);
    end
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid_o && n < 60) begin
      @(negedge pclk_i);
      n++;
    end
    check({tag, "_rsp_seen"}, rsp_valid_o, 1);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int   lat, acc, sel, w;
    logic bus_bad;
    exp_t e;
    e.rdata = v.exp_rdata;
    e.to    = v.exp_to;
    cmd_valid_i = 1'b1;
    cmd_write_i = v.write;
    cmd_addr_i  = v.addr;
    cmd_wdata_i = v.wdata;
    prdata_i    = v.prdata;
    pready_i    = v.tied;
    w = 0;
    while (!cmd_ready_o && w < 50) begin
      @(negedge pclk_i);
      w++;
    end
    check({tag, "_cmd_ready"}, cmd_ready_o, 1);
    sb_q.push_back(e);
    @(negedge pclk_i);
    cmd_valid_i = 1'b0;
    cmd_addr_i  = '1;
    cmd_wdata_i = '1;
    cmd_write_i = ~v.write;
    lat = 1;
    acc = 0;
    sel = 0;
    bus_bad = 1'b0;
    while (!rsp_valid_o && lat < 60) begin
      if (lat == 1) begin
        check({tag, "_setup_psel"}, psel_o, 1);
        check({tag, "_setup_penable"}, penable_o, 0);
      end
      if (psel_o) sel++;
      if (penable_o) begin
        acc++;
        pready_i = v.tied | (!v.stuck && acc == v.waits + 1);
      end else begin
        pready_i = v.tied;
      end
      if (psel_o && (paddr_o !== v.addr || pwdata_o !== v.wdata ||
                     pwrite_o !== v.write))
        bus_bad = 1'b1;
      @(negedge pclk_i);
      lat++;
    end
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_penable_cycles"}, acc, v.exp_acc);
    check({tag, "_psel_cycles"}, sel, acc + 1);
    check({tag, "_bus_stable"}, bus_bad, 0);
    check({tag, "_resp_psel"}, {psel_o, penable_o}, 0);
    sb_pop(tag);
    pready_i    = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge pclk_i);
    rsp_ready_i = 1'b0;
    check({tag, "_idle_rsp_valid"}, rsp_valid_o, 0);
    check({tag, "_idle_ready"}, {cmd_ready_o, busy_o, psel_o}, 3'b100);
    check({tag, "_idle_paddr"}, paddr_o, v.addr);
  endtask

  initial begin
    int   n;
    logic saw_rsp;
    exp_t e;

    vecs[0] = '{write:1'b1, addr:32'h8, wdata:32'hA5, prdata:32'h0,
                tied:1'b1, waits:0, stuck:1'b0, exp_rdata:32'h0,
                exp_to:1'b0, exp_acc:1, exp_lat:3};
    vecs[1] = '{write:1'b0, addr:32'hC, wdata:32'h0, prdata:32'h5A,
                tied:1'b0, waits:3, stuck:1'b0, exp_rdata:32'h5A,
                exp_to:1'b0, exp_acc:4, exp_lat:6};
    vecs[2] = '{write:1'b0, addr:32'h10, wdata:32'h0, prdata:32'hBAD0BAD0,
                tied:1'b0, waits:0, stuck:1'b1, exp_rdata:32'h0,
                exp_to:1'b1, exp_acc:16, exp_lat:18};
    vecs[3] = '{write:1'b0, addr:32'h14, wdata:32'h0, prdata:32'h12345678,
                tied:1'b0, waits:15, stuck:1'b0, exp_rdata:32'h12345678,
                exp_to:1'b0, exp_acc:16, exp_lat:18};
    vecs[4] = '{write:1'b1, addr:32'h18, wdata:32'hCAFE, prdata:32'hDEAD,
                tied:1'b0, waits:2, stuck:1'b0, exp_rdata:32'h0,
                exp_to:1'b0, exp_acc:3, exp_lat:5};
    vecs[5] = '{write:1'b1, addr:32'h1C, wdata:32'h55, prdata:32'hFFFF,
                tied:1'b0, waits:0, stuck:1'b1, exp_rdata:32'h0,
                exp_to:1'b1, exp_acc:16, exp_lat:18};
    vecs[6] = '{write:1'b0, addr:32'hFFFFFFFC, wdata:32'h0,
                prdata:32'hFFFFFFFF, tied:1'b1, waits:0, stuck:1'b0,
                exp_rdata:32'hFFFFFFFF, exp_to:1'b0, exp_acc:1, exp_lat:3};

    // Reset held from time zero: everything low, including ready.
    @(negedge pclk_i);
    @(negedge pclk_i);
    check("rst_ctrl", {cmd_ready_o, busy_o, psel_o, penable_o, pwrite_o,
                       rsp_valid_o, rsp_timeout_o}, 0);
    check("rst_data", {paddr_o, pwdata_o}, 0);
    check("rst_rdata", rsp_rdata_o, 0);
    prst_i = 1'b0;
    #1;
    check("post_rst", {cmd_ready_o, busy_o, psel_o, rsp_valid_o}, 4'b1000);
    @(negedge pclk_i);

    for (int i = 0; i < 7; i++)
      run_txn(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: response held 5 cycles, next command waiting.
    cmd_valid_i = 1'b1;
    cmd_write_i = 1'b0;
    cmd_addr_i  = 32'h20;
    cmd_wdata_i = 32'h0;
    prdata_i    = 32'h11112222;
    pready_i    = 1'b1;
    check("bp_ready0", cmd_ready_o, 1);
    e.rdata = 32'h11112222;
    e.to    = 1'b0;
    sb_q.push_back(e);
    @(negedge pclk_i);
    cmd_write_i = 1'b1;
    cmd_addr_i  = 32'h24;
    cmd_wdata_i = 32'h77;
    wait_rsp("bp_a");
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {rsp_valid_o, cmd_ready_o, psel_o}, 3'b100);
      check("bp_rdata", rsp_rdata_o, 32'h11112222);
      @(negedge pclk_i);
    end
    sb_pop("bp_a");
    rsp_ready_i = 1'b1;
    @(negedge pclk_i);
    rsp_ready_i = 1'b0;
    check("bp_idle", {cmd_ready_o, rsp_valid_o, psel_o}, 3'b100);
    check("bp_not_yet", paddr_o, 32'h20);
    e.rdata = 32'h0;
    e.to    = 1'b0;
    sb_q.push_back(e);
    @(negedge pclk_i);
    cmd_valid_i = 1'b0;
    check("bp_b_setup", {psel_o, penable_o, pwrite_o}, 3'b101);
    check("bp_b_addr", paddr_o, 32'h24);
    wait_rsp("bp_b");
    sb_pop("bp_b");
    rsp_ready_i = 1'b1;
    @(negedge pclk_i);
    rsp_ready_i = 1'b0;
    pready_i    = 1'b0;

    // Reset pulse in the middle of ACCESS.
    cmd_valid_i = 1'b1;
    cmd_write_i = 1'b0;
    cmd_addr_i  = 32'h30;
    @(negedge pclk_i);
    cmd_valid_i = 1'b0;
    n = 0;
    while (!penable_o && n < 10) begin
      @(negedge pclk_i);
      n++;
    end
    check("mid_penable", penable_o, 1);
    @(negedge pclk_i);
    #2;
    prst_i = 1'b1;
    #1;
    check("mid_rst_bus", {psel_o, penable_o, cmd_ready_o, busy_o,
                          rsp_valid_o}, 0);
    @(negedge pclk_i);
    prst_i = 1'b0;
    #1;
    check("mid_rel", {cmd_ready_o, busy_o, psel_o}, 3'b100);
    saw_rsp = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge pclk_i);
      if (rsp_valid_o || psel_o) saw_rsp = 1'b1;
    end
    check("mid_no_rsp", saw_rsp, 0);
    run_txn(vecs[1], "after_rst");

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
